iig_rect_reader: RTL



---
 rtl/iig_rect_reader.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/iig_rect_reader.sv
// Rectangle-sum reader for the integral-image BRAM.
// Each accepted rectangle (x, y, w, h) issues one read per corner A, B, C, D
// in fixed slots, tags every slot through a read-latency pipeline, and
// accumulates sum = D - B - C + A. Corners on row/column -1 are masked: they
// are not read and contribute zero. Illegal rectangles skip straight to DONE.
module iig_rect_reader #(
  parameter int unsigned IMG_W  = 80,
  parameter int unsigned IMG_H  = 60,
  parameter int unsigned RD_LAT = 2
) (
  input  logic        iClk,
  input  logic        iReset,
  input  logic        iEnable,
  input  logic        iReq_valid,
  output logic        oReq_ready,
  input  logic [6:0]  iX,
  input  logic [5:0]  iY,
  input  logic [6:0]  iW,
  input  logic [5:0]  iH,
  output logic        oRdreq_to_IIGBRAM,
  output logic [12:0] oAddr_to_IIGBRAM,
  input  logic [20:0] iData_from_IIGBRAM,
  output logic        oSum_valid,
  output logic [20:0] oSum,
  output logic        oErr
);

  localparam int unsigned WCW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t             state;
  logic [1:0]         slot;
  logic [WCW-1:0]     wait_cnt;
  logic [6:0]         x_q;
  logic [5:0]         y_q;
  logic [6:0]         w_q;
  logic [5:0]         h_q;
  logic               err_q;
  logic               issue_neg;
  logic signed [21:0] acc;

  logic [RD_LAT-1:0]  tag_vld;
  logic [RD_LAT-1:0]  tag_neg;

  logic               accept;
  logic               req_illegal;
  logic [7:0]         cx;
  logic [6:0]         cy;
  logic               corner_masked;
  logic [12:0]        corner_addr;
  logic signed [21:0] data_ext;
  logic signed [21:0] acc_next;

  // Handshake and legality of the request currently on the inputs.
  always_comb begin
    accept      = (state == IDLE) && iReq_valid && oReq_ready;
    req_illegal = (iW == 7'd0) || (iH == 6'd0) ||
                  ((32'(iX) + 32'(iW)) > IMG_W) ||
                  ((32'(iY) + 32'(iH)) > IMG_H);
  end

  // Corner coordinates for the current slot: bit 0 selects right column, bit 1 bottom row.
  always_comb begin
    cx = slot[0] ? (8'(x_q) + 8'(w_q) - 8'd1) : (8'(x_q) - 8'd1);
    cy = slot[1] ? (7'(y_q) + 7'(h_q) - 7'd1) : (7'(y_q) - 7'd1);
    corner_masked = (!slot[0] && (x_q == 7'd0)) || (!slot[1] && (y_q == 6'd0));
    corner_addr   = 13'(cy) * 13'(IMG_W) + 13'(cx);
  end

  // Add or subtract the word whose tag emerges this cycle; masked slots add nothing.
  always_comb begin
    data_ext = $signed({1'b0, iData_from_IIGBRAM});
    acc_next = acc;
    if (tag_vld[RD_LAT-1]) begin
      acc_next = tag_neg[RD_LAT-1] ? (acc - data_ext) : (acc + data_ext);
    end
  end

  // Tag pipeline aligned with BRAM read latency; the read strobe register is its input.
  always_ff @(posedge iClk) begin
    if (iReset) begin
      tag_vld <= '0;
      tag_neg <= '0;
    end else begin
      tag_vld[0] <= oRdreq_to_IIGBRAM;
      tag_neg[0] <= issue_neg;
      for (int i = 1; i < int'(RD_LAT); i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_neg[i] <= tag_neg[i-1];
      end
    end
  end

  // Control FSM with registered outputs.
  always_ff @(posedge iClk) begin
    if (iReset) begin
      state             <= IDLE;
      slot              <= 2'd0;
      wait_cnt          <= '0;
      x_q               <= 7'd0;
      y_q               <= 6'd0;
      w_q               <= 7'd0;
      h_q               <= 6'd0;
      err_q             <= 1'b0;
      issue_neg         <= 1'b0;
      acc               <= '0;
      oReq_ready        <= 1'b0;
      oRdreq_to_IIGBRAM <= 1'b0;
      oAddr_to_IIGBRAM  <= 13'd0;
      oSum_valid        <= 1'b0;
      oSum              <= 21'd0;
      oErr              <= 1'b0;
    end else begin
      oSum_valid <= 1'b0;
      acc        <= accept ? 22'sd0 : acc_next;
      case (state)
        IDLE: begin
          oRdreq_to_IIGBRAM <= 1'b0;
          oAddr_to_IIGBRAM  <= 13'd0;
          if (accept) begin
            oReq_ready <= 1'b0;
            x_q        <= iX;
            y_q        <= iY;
            w_q        <= iW;
            h_q        <= iH;
            err_q      <= req_illegal;
            slot       <= 2'd0;
            state      <= req_illegal ? DONE : ISSUE;
          end else begin
            oReq_ready <= iEnable;
          end
        end
        ISSUE: begin
          oRdreq_to_IIGBRAM <= !corner_masked;
          oAddr_to_IIGBRAM  <= corner_masked ? 13'd0 : corner_addr;
          issue_neg         <= slot[0] ^ slot[1];
          slot              <= slot + 2'd1;
          if (slot == 2'd3) begin
            wait_cnt <= '0;
            state    <= WAIT;
          end
        end
        WAIT: begin
          oRdreq_to_IIGBRAM <= 1'b0;
          oAddr_to_IIGBRAM  <= 13'd0;
          wait_cnt          <= wait_cnt + WCW'(1);
          if (wait_cnt == WCW'(RD_LAT - 1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          oRdreq_to_IIGBRAM <= 1'b0;
          oAddr_to_IIGBRAM  <= 13'd0;
          oSum_valid        <= 1'b1;
          oSum              <= err_q ? 21'd0 : acc_next[20:0];
          oErr              <= err_q;
          oReq_ready        <= iEnable;
          state             <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
